// File: rtl/vga_multi_timing.sv
// VGA timing generator with pixel enable, sync/blank, scaled coordinates and per-channel change strobes.
// Define VGA_FRAME_SYNC_EN to hold pending change strobes until the start of vertical blank.
module vga_multi_timing #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned NCHAN       = 2,
  parameter int unsigned STRETCH     = 4
) (
  input  logic                      clk_100mhz,
  input  logic                      rst,
  output logic                      pix_en,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      comp_sync,
  output logic                      blank,
  output logic [10-SCALE_SHIFT-1:0] pixel_x,
  output logic [10-SCALE_SHIFT-1:0] pixel_y,
  output logic                      frame_tick,
  input  logic [NCHAN-1:0]          chg_req,
  output logic [NCHAN-1:0]          chg_strobe,
  output logic                      chg_busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);
  localparam int unsigned PIX_W   = 10 - SCALE_SHIFT;
  localparam int unsigned CNT_W   = (STRETCH > 1) ? $clog2(STRETCH) : 1;

  typedef enum logic [1:0] {IDLE, PEND, STROBE} chan_state_t;

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [H_W-1:0]   hcount, h_nxt;
  logic [V_W-1:0]   vcount, v_nxt;
  logic             line_wrap;
  logic             hsync_nxt, vsync_nxt, blank_nxt;

  chan_state_t      state     [NCHAN];
  chan_state_t      state_nxt [NCHAN];
  logic [CNT_W-1:0] cnt       [NCHAN];
  logic [CNT_W-1:0] cnt_nxt   [NCHAN];
  logic [NCHAN-1:0] queued, queued_nxt, req_q, edge_det, strobe_nxt;
  logic             busy_nxt, pend_release;

`ifdef VGA_FRAME_SYNC_EN
  assign pend_release = frame_tick;
`else
  assign pend_release = 1'b1;
`endif

  // Next counter values; outputs are decoded from these so they align with the counters.
  always_comb begin
    div_nxt   = (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
    h_nxt     = hcount;
    v_nxt     = vcount;
    line_wrap = 1'b0;
    if (pix_en) begin
      if (hcount == H_W'(H_TOTAL - 1)) begin
        h_nxt     = '0;
        line_wrap = 1'b1;
        v_nxt     = (vcount == V_W'(V_TOTAL - 1)) ? '0 : vcount + V_W'(1);
      end else begin
        h_nxt = hcount + H_W'(1);
      end
    end
    hsync_nxt = !((32'(h_nxt) >= H_ACTIVE + H_FP) && (32'(h_nxt) < H_ACTIVE + H_FP + H_SYNC));
    vsync_nxt = !((32'(v_nxt) >= V_ACTIVE + V_FP) && (32'(v_nxt) < V_ACTIVE + V_FP + V_SYNC));
    blank_nxt = (32'(h_nxt) >= H_ACTIVE) || (32'(v_nxt) >= V_ACTIVE);
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      div_cnt    <= '0;
      hcount     <= '0;
      vcount     <= '0;
      pix_en     <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      comp_sync  <= 1'b1;
      blank      <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      hcount     <= h_nxt;
      vcount     <= v_nxt;
      pix_en     <= (div_nxt == DIV_W'(CLK_DIV - 1));
      hsync      <= hsync_nxt;
      vsync      <= vsync_nxt;
      comp_sync  <= hsync_nxt & vsync_nxt;
      blank      <= blank_nxt;
      pixel_x    <= blank_nxt ? '0 : PIX_W'(h_nxt >> SCALE_SHIFT);
      pixel_y    <= blank_nxt ? '0 : PIX_W'(v_nxt >> SCALE_SHIFT);
      frame_tick <= line_wrap && (32'(v_nxt) == V_ACTIVE);
    end
  end

  // Per-channel IDLE/PEND/STROBE with a one-deep queue for edges seen mid-strobe.
  always_comb begin
    edge_det = chg_req & ~req_q;
    busy_nxt = 1'b0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      state_nxt[i]  = state[i];
      cnt_nxt[i]    = cnt[i];
      queued_nxt[i] = queued[i];
      case (state[i])
        IDLE: if (edge_det[i]) state_nxt[i] = PEND;
        PEND: begin
          if (pend_release) begin
            state_nxt[i] = STROBE;
            cnt_nxt[i]   = '0;
            if (edge_det[i]) queued_nxt[i] = 1'b1;
          end
        end
        STROBE: begin
          if (cnt[i] == CNT_W'(STRETCH - 1)) begin
            cnt_nxt[i]    = '0;
            queued_nxt[i] = 1'b0;
            state_nxt[i]  = (queued[i] || edge_det[i]) ? PEND : IDLE;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
            if (edge_det[i]) queued_nxt[i] = 1'b1;
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
      strobe_nxt[i] = (state_nxt[i] == STROBE);
      busy_nxt      = busy_nxt | (state_nxt[i] != IDLE);
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCHAN; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      queued     <= '0;
      req_q      <= '0;
      chg_strobe <= '0;
      chg_busy   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCHAN; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      queued     <= queued_nxt;
      req_q      <= chg_req;
      chg_strobe <= strobe_nxt;
      chg_busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_vga_multi_timing.sv
// Scoreboard bench for vga_multi_timing: closed-form timing model plus directed change-channel sequences.
module tb_vga_multi_timing;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int unsigned VA = 12, VF = 2, VS = 2, VB = 4;
  localparam int unsigned SS = 1, NCH = 2, STR = 4;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned PW = 10 - SS;
  localparam int unsigned F0 = CLK_DIV * HT * VA;

  localparam int K_TIM = 0;
  localparam int K_STB = 1;
  localparam int K_BSY = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pix_en, hsync, vsync, comp_sync, blank, frame_tick, chg_busy;
  logic [PW-1:0]  pixel_x, pixel_y;
  logic [NCH-1:0] chg_req = '0;
  logic [NCH-1:0] chg_strobe;
  logic [23:0]    timing_vec;

  vga_multi_timing #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE_SHIFT(SS), .NCHAN(NCH), .STRETCH(STR)
  ) dut (
    .clk_100mhz(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .comp_sync(comp_sync), .blank(blank), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_tick(frame_tick), .chg_req(chg_req), .chg_strobe(chg_strobe), .chg_busy(chg_busy)
  );

  always #5 clk = ~clk;

  assign timing_vec = {pix_en, hsync, vsync, comp_sync, blank, pixel_x, pixel_y, frame_tick};

  // Clocks since the last edge that sampled rst high.
  int unsigned n = 0;
  always @(posedge clk) n <= rst ? 0 : n + 1;

  typedef struct {
    int          kind;
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] exp_timing(input int unsigned c);
    int unsigned h, v, px, py;
    logic pe, hs, vs, bl, ft;
    h  = (c / CLK_DIV) % HT;
    v  = (c / (CLK_DIV * HT)) % VT;
    pe = (c % CLK_DIV) == CLK_DIV - 1;
    hs = !(h >= HA + HF && h < HA + HF + HS);
    vs = !(v >= VA + VF && v < VA + VF + VS);
    bl = (h >= HA) || (v >= VA);
    px = bl ? 0 : h >> SS;
    py = bl ? 0 : v >> SS;
    ft = (c > 0) && ((c % (CLK_DIV * HT * VT)) == F0);
    return {pe, hs, vs, hs & vs, bl, PW'(px), PW'(py), ft};
  endfunction

  task automatic expect_val(input int kind, input string tag, input logic [31:0] e);
    sb_t x;
    x.kind = kind;
    x.tag  = $sformatf("%s@%0d", tag, n);
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    expect_val(K_TIM, "timing", 32'(exp_timing(n)));
  endtask

  task automatic expect_chan(input string tag, input logic [NCH-1:0] stb, input logic busy);
    expect_val(K_STB, {tag, "_strobe"}, 32'(stb));
    expect_val(K_BSY, {tag, "_busy"}, 32'(busy));
  endtask

  task automatic run_until(input int unsigned target);
    while (n < target) tick();
  endtask

  always @(negedge clk) begin : monitor
    sb_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_TIM:   obs = 32'(timing_vec);
        K_STB:   obs = 32'(chg_strobe);
        default: obs = 32'(chg_busy);
      endcase
      check(e.tag, obs, e.exp);
    end
  end

  initial begin
    rst = 1'b1;
    chg_req = '0;
    repeat (5) begin
      tick();
      expect_chan("reset", '0, 1'b0);
    end
    rst = 1'b0;
    run_until(100);

`ifdef VGA_FRAME_SYNC_EN
    // One pulse mid-frame must wait for frame_tick, then strobe for STR clocks.
    chg_req[0] = 1'b1;
    tick();
    chg_req[0] = 1'b0;
    expect_chan("fsync", '0, 1'b1);
    while (n < F0 + 10) begin
      tick();
      expect_chan("fsync", {1'b0, (n >= F0 + 1) && (n <= F0 + STR)}, n <= F0 + STR);
    end
    run_until(2700);
`else
    // Level held high: only its rising edge produces a strobe.
    for (int t = 0; t < 11; t++) begin
      chg_req[0] = (t <= 6);
      tick();
      expect_chan("level", {1'b0, (t >= 1) && (t <= 4)}, t <= 4);
    end
    chg_req = '0;
    run_until(200);

    // Three edges, two during STROBE: exactly two strobes with one PEND clock between.
    for (int t = 0; t < 13; t++) begin
      chg_req[1] = (t == 0) || (t == 2) || (t == 4);
      tick();
      expect_chan("queue", {((t >= 1) && (t <= 4)) || ((t >= 6) && (t <= 9)), 1'b0}, t <= 9);
    end
    chg_req = '0;
    run_until(2700);

    // Reset during the second strobe clock truncates it; nothing resumes afterwards.
    for (int t = 0; t < 13; t++) begin
      chg_req[0] = (t == 0);
      rst = (t == 3);
      tick();
      expect_chan("rst_mid", {1'b0, (t == 1) || (t == 2)}, t <= 2);
    end
    rst = 1'b0;
    chg_req = '0;
`endif

    run_until(300);
    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
